// File: rtl/scan_ascii_fifo.sv
// Scan-code to ASCII translator feeding a first-word-fall-through character FIFO.
// One register stage captures each strobe; the lookup and write decision follow a cycle later.
module scan_ascii_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        scan_code,
  input  logic              scan_code_ready,
  input  logic              letter_case,
  input  logic              rd_en,
  input  logic              clear_overflow,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              unmapped_tick
);

  localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] LP_PTR_ONE = 1;

  logic [7:0]        r_code_s1;
  logic              r_case_s1;
  logic              r_valid_s1;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [7:0]        r_mem [DEPTH];

  logic [7:0]        w_base;
  logic              w_is_letter;
  logic              w_mapped;
  logic [7:0]        w_ascii;
  logic              w_wr;
  logic              w_rd;
  logic              w_ovf_set;

  // Stage 1: capture the strobed code and case flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code_s1  <= 8'h00;
      r_case_s1  <= 1'b0;
      r_valid_s1 <= 1'b0;
    end else begin
      r_valid_s1 <= scan_code_ready;
      if (scan_code_ready) begin
        r_code_s1 <= scan_code;
        r_case_s1 <= letter_case;
      end
    end
  end

  // Lookup yields lower-case base; 0x00 marks an unmapped code since no mapped value is zero.
  always_comb begin
    w_base = 8'h00;
    case (r_code_s1)
      8'h1C: w_base = 8'h61;
      8'h32: w_base = 8'h62;
      8'h21: w_base = 8'h63;
      8'h23: w_base = 8'h64;
      8'h24: w_base = 8'h65;
      8'h2B: w_base = 8'h66;
      8'h34: w_base = 8'h67;
      8'h33: w_base = 8'h68;
      8'h43: w_base = 8'h69;
      8'h3B: w_base = 8'h6A;
      8'h42: w_base = 8'h6B;
      8'h4B: w_base = 8'h6C;
      8'h3A: w_base = 8'h6D;
      8'h31: w_base = 8'h6E;
      8'h44: w_base = 8'h6F;
      8'h4D: w_base = 8'h70;
      8'h15: w_base = 8'h71;
      8'h2D: w_base = 8'h72;
      8'h1B: w_base = 8'h73;
      8'h2C: w_base = 8'h74;
      8'h3C: w_base = 8'h75;
      8'h2A: w_base = 8'h76;
      8'h1D: w_base = 8'h77;
      8'h22: w_base = 8'h78;
      8'h35: w_base = 8'h79;
      8'h1A: w_base = 8'h7A;
      8'h45: w_base = 8'h30;
      8'h16: w_base = 8'h31;
      8'h1E: w_base = 8'h32;
      8'h26: w_base = 8'h33;
      8'h25: w_base = 8'h34;
      8'h2E: w_base = 8'h35;
      8'h36: w_base = 8'h36;
      8'h3D: w_base = 8'h37;
      8'h3E: w_base = 8'h38;
      8'h46: w_base = 8'h39;
      8'h29: w_base = 8'h20;
      8'h5A: w_base = 8'h0D;
      8'h66: w_base = 8'h08;
      default: w_base = 8'h00;
    endcase
  end

  assign w_is_letter = (w_base >= 8'h61) && (w_base <= 8'h7A);
  assign w_mapped    = (w_base != 8'h00);
  assign w_ascii     = (w_is_letter && r_case_s1) ? (w_base - 8'h20) : w_base;

  // A read at full frees the slot the same cycle, so the write is still accepted.
  assign w_rd      = rd_en && (r_count != '0);
  assign w_wr      = r_valid_s1 && w_mapped && ((r_count != LP_DEPTH) || rd_en);
  assign w_ovf_set = r_valid_s1 && w_mapped && (r_count == LP_DEPTH) && !rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      if (w_wr && !w_rd)      r_count <= r_count + LP_CNT_ONE;
      else if (w_rd && !w_wr) r_count <= r_count - LP_CNT_ONE;
      if (w_ovf_set)           r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_ascii;
  end

  assign rd_data       = r_mem[r_rd_ptr];
  assign count         = r_count;
  assign empty         = (r_count == '0);
  assign full          = (r_count == LP_DEPTH);
  assign overflow      = r_overflow;
  assign unmapped_tick = r_valid_s1 && !w_mapped;

endmodule

// File: tb/tb_scan_ascii_fifo.sv
// Bench for scan_ascii_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_scan_ascii_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        scan_code;
  logic              scan_code_ready;
  logic              letter_case;
  logic              rd_en;
  logic              clear_overflow;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              unmapped_tick;

  scan_ascii_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_code_ready(scan_code_ready),
    .letter_case(letter_case), .rd_en(rd_en), .clear_overflow(clear_overflow),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .overflow(overflow),
    .unmapped_tick(unmapped_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: translation table, character queue, pending strobe, sticky flag.
  logic [7:0] map_val [256];
  logic [7:0] mapped_codes [39];
  logic [7:0] q [$];
  logic       p_valid;
  logic [7:0] p_code;
  logic       p_case;
  logic       m_ovf;

  task automatic init_map();
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46};
    for (int i = 0; i < 256; i++) map_val[i] = 8'h00;
    for (int i = 0; i < 26; i++) begin
      map_val[letters[i]] = 8'h61 + 8'(i);
      mapped_codes[i] = letters[i];
    end
    for (int i = 0; i < 10; i++) begin
      map_val[digits[i]] = 8'h30 + 8'(i);
      mapped_codes[26+i] = digits[i];
    end
    map_val[8'h29] = 8'h20; map_val[8'h5A] = 8'h0D; map_val[8'h66] = 8'h08;
    mapped_codes[36] = 8'h29; mapped_codes[37] = 8'h5A; mapped_codes[38] = 8'h66;
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic lc);
    logic [7:0] v;
    v = map_val[c];
    if (lc && v >= 8'h61 && v <= 8'h7A) v = v - 8'h20;
    return v;
  endfunction

  function automatic logic exp_unmapped();
    return p_valid && (map_val[p_code] == 8'h00);
  endfunction

  // Drive one cycle's inputs at a falling edge, advance the model, return at the next falling edge.
  task automatic tick(input logic stb, input logic [7:0] code, input logic lc,
                      input logic rd, input logic clr);
    logic [7:0] ch;
    int         sz;
    logic       rd_eff;
    logic       set;
    scan_code_ready = stb; scan_code = code; letter_case = lc;
    rd_en = rd; clear_overflow = clr;
    sz     = q.size();
    rd_eff = rd && (sz > 0);
    ch     = ref_ascii(p_code, p_case);
    set    = 1'b0;
    if (rd_eff) void'(q.pop_front());
    if (p_valid && ch != 8'h00) begin
      if (sz < DEPTH || rd_eff) q.push_back(ch);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    p_valid = stb; p_code = code; p_case = lc;
    @(posedge clk);
    @(negedge clk);
    scan_code_ready = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scan_code = 8'h00; scan_code_ready = 1'b0; letter_case = 1'b0;
    rd_en = 1'b0; clear_overflow = 1'b0;
    p_valid = 1'b0; p_code = 8'h00; p_case = 1'b0; m_ovf = 1'b0; q.delete();
    @(negedge clk); @(negedge clk);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (unmapped_tick !== 1'b0) begin n_fail++; $display("FAIL reset_unmapped got=%b exp=0", unmapped_tick); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    tick(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_n1_empty got=%b exp=1", empty); end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_n2_empty got=%b exp=0", empty); end
    n_checks++; if (rd_data !== 8'h61) begin n_fail++; $display("FAIL single_data got=%h exp=61", rd_data); end
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1 || count !== 5'(q.size())) begin
      n_fail++; $display("FAIL single_pop empty=%b count=%0d exp empty=1 count=%0d", empty, count, q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [3] = '{8'h41, 8'h31, 8'h20};
    tick(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h29, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rd_data !== exp_seq[i] || rd_data !== q[0]) begin
        n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, exp_seq[i]);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_unmapped();
    tick(1'b1, 8'h76, 1'b0, 1'b0, 1'b0);
    n_checks++; if (unmapped_tick !== 1'b1) begin n_fail++; $display("FAIL unmapped_pulse got=%b exp=1", unmapped_tick); end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (unmapped_tick !== 1'b0) begin n_fail++; $display("FAIL unmapped_end got=%b exp=0", unmapped_tick); end
    n_checks++; if (count !== '0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_state count=%0d ovf=%b exp count=0 ovf=0", count, overflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL ovf_fill full=%b count=%0d exp full=1 count=16", full, count);
    end
    tick(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL ovf_set ovf=%b count=%0d exp ovf=1 count=16", overflow, count);
    end
    n_checks++; if (rd_data !== 8'h61) begin n_fail++; $display("FAIL ovf_head got=%h exp=61", rd_data); end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // Set and clear land in the same cycle: set must win.
    tick(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++; if (overflow !== m_ovf || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_priority got=%b exp=1", overflow);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_rdwr();
    logic [7:0] last;
    last = 8'h00;
    tick(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rdwr_full count=%0d ovf=%b exp count=16 ovf=0", count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (rd_data !== q[0]) begin
        n_fail++; $display("FAIL rdwr_drain[%0d] got=%h exp=%h", i, rd_data, q[0]);
      end
      last = rd_data;
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    n_checks++; if (last !== 8'h62 || empty !== 1'b1) begin
      n_fail++; $display("FAIL rdwr_last got=%h empty=%b exp=62 empty=1", last, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h24, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    q.delete(); p_valid = 1'b0; m_ovf = 1'b0;
    n_checks++; if (empty !== 1'b1 || count !== '0) begin
      n_fail++; $display("FAIL rstmid_now empty=%b count=%0d exp empty=1 count=0", empty, count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (empty !== 1'b1 || count !== '0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after empty=%b count=%0d ovf=%b exp 1/0/0", empty, count, overflow);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7) c = mapped_codes[$urandom_range(0, 38)];
      else c = 8'($urandom_range(0, 255));
      tick(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
      n_checks++; if (count !== 5'(q.size()) || empty !== (q.size() == 0) ||
                      full !== (q.size() == DEPTH) || overflow !== m_ovf ||
                      unmapped_tick !== exp_unmapped()) begin
        n_fail++;
        $display("FAIL rand_state[%0d] count=%0d empty=%b full=%b ovf=%b unm=%b exp count=%0d ovf=%b unm=%b",
                 i, count, empty, full, overflow, unmapped_tick, q.size(), m_ovf, exp_unmapped());
      end
      if (q.size() > 0) begin
        n_checks++; if (rd_data !== q[0]) begin
          n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, rd_data, q[0]);
        end
      end
    end
  endtask

  initial begin
    init_map();
    test_reset();
    test_single();
    test_back_to_back();
    test_unmapped();
    test_overflow();
    test_full_rdwr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
